tlb_array: RTL

//  Parametrised fully-associative MIPS32 JTLB with internal entry storage. Serves one

---
 rtl/tlb_array.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/tlb_array.sv
// tlb_array: fully-associative MIPS32 JTLB with internal entry storage.
//
// Two independent lookup ports (instruction and data) return registered results
// one cycle after the request. A CP0 side supports indexed and random writes
// (TLBWI/TLBWR), a combinational indexed read (TLBR), a one-cycle probe (TLBP),
// the Random replacement counter bounded below by Wired, and a valid-bit flush.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   asid                          current ASID for lookups and probe
//   i_req/i_vaddr -> i_ack/i_paddr/i_miss/i_invalid           instruction lookup
//   d_req/d_vaddr -> d_ack/d_paddr/d_miss/d_invalid/d_dirty   data lookup
//   we/we_rand/w_index/w_entry    entry write (random slot when we_rand=1)
//   r_index -> r_entry            entry read
//   probe_req/probe_vpn2 -> probe_done/probe_miss/probe_idx
//   wired/wired_we -> random_idx  replacement counter
//   flush                         clear V0/V1 of all entries
module tlb_array #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IDX_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       asid,
    input  logic             i_req,
    input  logic [31:0]      i_vaddr,
    output logic             i_ack,
    output logic [31:0]      i_paddr,
    output logic             i_miss,
    output logic             i_invalid,
    input  logic             d_req,
    input  logic [31:0]      d_vaddr,
    output logic             d_ack,
    output logic [31:0]      d_paddr,
    output logic             d_miss,
    output logic             d_invalid,
    output logic             d_dirty,
    input  logic             we,
    input  logic             we_rand,
    input  logic [IDX_W-1:0] w_index,
    input  logic [79:0]      w_entry,
    input  logic [IDX_W-1:0] r_index,
    output logic [79:0]      r_entry,
    input  logic             probe_req,
    input  logic [18:0]      probe_vpn2,
    output logic             probe_done,
    output logic             probe_miss,
    output logic [IDX_W-1:0] probe_idx,
    input  logic [IDX_W-1:0] wired,
    input  logic             wired_we,
    output logic [IDX_W-1:0] random_idx,
    input  logic             flush
);

    typedef struct packed {
        logic [7:0]  asid;
        logic        g;
        logic [18:0] vpn2;
        logic [23:0] pfn1;
        logic        d1;
        logic        v1;
        logic [23:0] pfn0;
        logic        d0;
        logic        v0;
    } tlb_entry_t;

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(ENTRIES - 1);

    tlb_entry_t       entry_q [ENTRIES];
    logic [IDX_W-1:0] random_q, random_d;
    logic [IDX_W-1:0] w_idx;

    logic [ENTRIES-1:0] i_match, d_match, p_match;
    logic [IDX_W-1:0]   i_sel, d_sel, p_sel;
    logic [19:0]        i_pfn, d_pfn;
    logic               i_v, d_v, d_d;

    logic        i_ack_q, i_miss_q, i_invalid_q;
    logic [31:0] i_paddr_q;
    logic        d_ack_q, d_miss_q, d_invalid_q, d_dirty_q;
    logic [31:0] d_paddr_q;
    logic             probe_done_q, probe_miss_q;
    logic [IDX_W-1:0] probe_idx_q;

    // Tag compare against every entry for all three search ports.
    always_comb begin
        for (int k = 0; k < int'(ENTRIES); k++) begin
            i_match[k] = (entry_q[k].vpn2 == i_vaddr[31:13]) &&
                         (entry_q[k].g || (entry_q[k].asid == asid));
            d_match[k] = (entry_q[k].vpn2 == d_vaddr[31:13]) &&
                         (entry_q[k].g || (entry_q[k].asid == asid));
            p_match[k] = (entry_q[k].vpn2 == probe_vpn2) &&
                         (entry_q[k].g || (entry_q[k].asid == asid));
        end
    end

    // Priority encode: scanning downwards leaves the lowest matching index.
    always_comb begin
        i_sel = '0;
        d_sel = '0;
        p_sel = '0;
        for (int k = int'(ENTRIES) - 1; k >= 0; k--) begin
            if (i_match[k]) i_sel = IDX_W'(k);
            if (d_match[k]) d_sel = IDX_W'(k);
            if (p_match[k]) p_sel = IDX_W'(k);
        end
    end

    // vaddr[12] picks the odd page of the pair.
    always_comb begin
        i_pfn = i_vaddr[12] ? entry_q[i_sel].pfn1[19:0] : entry_q[i_sel].pfn0[19:0];
        i_v   = i_vaddr[12] ? entry_q[i_sel].v1 : entry_q[i_sel].v0;
        d_pfn = d_vaddr[12] ? entry_q[d_sel].pfn1[19:0] : entry_q[d_sel].pfn0[19:0];
        d_v   = d_vaddr[12] ? entry_q[d_sel].v1 : entry_q[d_sel].v0;
        d_d   = d_vaddr[12] ? entry_q[d_sel].d1 : entry_q[d_sel].d0;
    end

    always_comb begin
        if (wired_we || (random_q <= wired)) begin
            random_d = LastIdx;
        end else begin
            random_d = random_q - 1'b1;
        end
    end

    // TLBWR uses the counter value of the write cycle, before it advances.
    assign w_idx = we_rand ? random_q : w_index;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(ENTRIES); k++) begin
                entry_q[k] <= '0;
            end
            random_q     <= LastIdx;
            i_ack_q      <= 1'b0;
            i_miss_q     <= 1'b0;
            i_invalid_q  <= 1'b0;
            i_paddr_q    <= '0;
            d_ack_q      <= 1'b0;
            d_miss_q     <= 1'b0;
            d_invalid_q  <= 1'b0;
            d_dirty_q    <= 1'b0;
            d_paddr_q    <= '0;
            probe_done_q <= 1'b0;
            probe_miss_q <= 1'b0;
            probe_idx_q  <= '0;
        end else begin
            random_q <= random_d;

            // Flush wins over a same-cycle write; tags survive the flush.
            if (flush) begin
                for (int k = 0; k < int'(ENTRIES); k++) begin
                    entry_q[k].v0 <= 1'b0;
                    entry_q[k].v1 <= 1'b0;
                end
            end else if (we) begin
                entry_q[w_idx] <= tlb_entry_t'(w_entry);
            end

            i_ack_q <= i_req;
            if (i_req) begin
                i_miss_q    <= ~|i_match;
                i_invalid_q <= (|i_match) & ~i_v;
                i_paddr_q   <= (|i_match) ? {i_pfn, i_vaddr[11:0]} : 32'h0;
            end

            d_ack_q <= d_req;
            if (d_req) begin
                d_miss_q    <= ~|d_match;
                d_invalid_q <= (|d_match) & ~d_v;
                d_dirty_q   <= (|d_match) & d_d;
                d_paddr_q   <= (|d_match) ? {d_pfn, d_vaddr[11:0]} : 32'h0;
            end

            probe_done_q <= probe_req;
            if (probe_req) begin
                probe_miss_q <= ~|p_match;
                probe_idx_q  <= p_sel;
            end
        end
    end

    assign i_ack      = i_ack_q;
    assign i_miss     = i_miss_q;
    assign i_invalid  = i_invalid_q;
    assign i_paddr    = i_paddr_q;
    assign d_ack      = d_ack_q;
    assign d_miss     = d_miss_q;
    assign d_invalid  = d_invalid_q;
    assign d_dirty    = d_dirty_q;
    assign d_paddr    = d_paddr_q;
    assign probe_done = probe_done_q;
    assign probe_miss = probe_miss_q;
    assign probe_idx  = probe_idx_q;
    assign random_idx = random_q;
    assign r_entry    = entry_q[r_index];

endmodule
